// File: rtl/rvfi_chk_pkg.sv
// ============================================================================
//  Module  : rvfi_chk_pkg
//  Purpose : Shared types and constants for the RVFI retirement-stream checker.
//            - err_code_e : violation codes, numerically ordered by priority
//                           (the lowest code wins when several hit at once)
//            - state_e    : checker state machine encoding
//            - pick_err() : priority pick of the lowest violation code
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rvfi_chk_pkg;

  localparam int unsigned ORDER_W         = 64;
  localparam int unsigned REG_ADDR_W      = 5;
  localparam int unsigned NUM_SHADOW_REGS = 31;
  localparam int unsigned RETIRE_CNT_W    = 32;
  localparam int unsigned ERR_CODE_W      = 4;

  typedef enum logic [ERR_CODE_W-1:0] {
    ERR_NONE         = 4'd0,
    ERR_ORDER        = 4'd1,
    ERR_PC           = 4'd2,
    ERR_RESET_PC     = 4'd3,
    ERR_X0_WRITE     = 4'd4,
    ERR_X0_READ      = 4'd5,
    ERR_HALT_RETIRE  = 4'd6,
    ERR_REG_MISMATCH = 4'd7
  } err_code_e;

  typedef enum logic [1:0] {
    ST_WAIT_FIRST = 2'd0,
    ST_RUN        = 2'd1,
    ST_HALTED     = 2'd2,
    ST_ERROR      = 2'd3
  } state_e;

  // hits[n] set means violation code n fired this cycle. Scanning from the
  // top down leaves the lowest set code in the result.
  function automatic err_code_e pick_err(input logic [7:1] hits);
    err_code_e code;
    code = ERR_NONE;
    for (int i = 7; i >= 1; i--) begin
      if (hits[i]) begin
        code = err_code_e'(i[3:0]);
      end
    end
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rvfi_stream_checker_if.sv
// ============================================================================
//  Module  : rvfi_stream_checker_if
//  Purpose : Single-channel RVFI retirement bundle.
//            master modport : the core (or a bench) driving retirements
//            slave  modport : the stream checker consuming them
//  Params  : XLEN - data/PC width
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rvfi_stream_checker_if #(
  parameter int unsigned XLEN = 32
);

  logic            rvfi_valid;
  logic [63:0]     rvfi_order;
  logic [31:0]     rvfi_insn;
  logic            rvfi_trap;
  logic            rvfi_halt;
  logic            rvfi_intr;
  logic [4:0]      rvfi_rs1_addr;
  logic [4:0]      rvfi_rs2_addr;
  logic [XLEN-1:0] rvfi_rs1_rdata;
  logic [XLEN-1:0] rvfi_rs2_rdata;
  logic [4:0]      rvfi_rd_addr;
  logic [XLEN-1:0] rvfi_rd_wdata;
  logic [XLEN-1:0] rvfi_pc_rdata;
  logic [XLEN-1:0] rvfi_pc_wdata;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
           rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
           rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata
  );

  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
           rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata,
           rvfi_rd_addr, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata
  );

endinterface

`default_nettype wire

// File: rtl/rvfi_shadow_regs.sv
// ============================================================================
//  Module  : rvfi_shadow_regs
//  Purpose : Shadow copy of x1..x31 with a "known" bit per register, used to
//            check that register reads return the last retired write.
//  Ports   : clk, resetn        - clock, asynchronous active-low reset
//            rs1_addr/rs2_addr  - combinational read addresses
//            rs1_data/rs2_data  - shadow value (0 for x0)
//            rs1_known/rs2_known- register has been written since reset
//            we, waddr, wdata   - write port (x0 writes are ignored)
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rvfi_shadow_regs
  import rvfi_chk_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic                  rs1_known,
  output logic                  rs2_known,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]       wdata
);

  logic [XLEN-1:0]            regs_q  [1:NUM_SHADOW_REGS];
  logic [XLEN-1:0]            regs_d  [1:NUM_SHADOW_REGS];
  logic [NUM_SHADOW_REGS:1]   known_q;
  logic [NUM_SHADOW_REGS:1]   known_d;

  always_comb begin
    regs_d  = regs_q;
    known_d = known_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr]  = wdata;
      known_d[waddr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 1; i <= NUM_SHADOW_REGS; i++) begin
        regs_q[i] <= '0;
      end
      known_q <= '0;
    end else begin
      regs_q  <= regs_d;
      known_q <= known_d;
    end
  end

  // Reads see state from before this cycle's write, so an instruction that
  // reads and writes the same register is checked against the old value.
  always_comb begin
    rs1_known = 1'b0;
    rs2_known = 1'b0;
    rs1_data  = '0;
    rs2_data  = '0;
    if (rs1_addr != '0) begin
      rs1_known = known_q[rs1_addr];
      rs1_data  = regs_q[rs1_addr];
    end
    if (rs2_addr != '0) begin
      rs2_known = known_q[rs2_addr];
      rs2_data  = regs_q[rs2_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/rvfi_stream_checker.sv
// ============================================================================
//  Module  : rvfi_stream_checker
//  Purpose : Cross-instruction checker on the RVFI retirement stream: order
//            continuity, PC continuity, x0 discipline, post-halt silence and
//            (optional) read-after-write consistency against a shadow
//            register file. Violations raise sticky error flags.
//  Config  : define RVFI_CHK_REGFILE_EN to build the shadow register file
//            check (err_code 7); without it code 7 never occurs.
//  Params  : XLEN, RESET_PC, CHECK_RESET_PC
//  Ports   : clk, resetn   - clock, asynchronous active-low reset
//            rvfi          - retirement stream (slave modport)
//            err           - sticky violation flag
//            err_code      - code of the first violation (frozen)
//            err_order     - rvfi_order of the first violating retirement
//            retired_cnt   - accepted retirements, saturating
//            halted        - a halting retirement has been accepted
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rvfi_stream_checker
  import rvfi_chk_pkg::*;
#(
  parameter int unsigned    XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC      = '0,
  parameter bit             CHECK_RESET_PC = 1'b1
) (
  input  logic                    clk,
  input  logic                    resetn,
  rvfi_stream_checker_if.slave    rvfi,
  output logic                    err,
  output logic [ERR_CODE_W-1:0]   err_code,
  output logic [ORDER_W-1:0]      err_order,
  output logic [RETIRE_CNT_W-1:0] retired_cnt,
  output logic                    halted
);

  state_e                  state_q,       state_d;
  logic [ORDER_W-1:0]      exp_order_q,   exp_order_d;
  logic [XLEN-1:0]         exp_pc_q,      exp_pc_d;
  logic                    err_q,         err_d;
  err_code_e               err_code_q,    err_code_d;
  logic [ORDER_W-1:0]      err_order_q,   err_order_d;
  logic [RETIRE_CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic                    halted_q,      halted_d;

  logic [7:1] hits;
  logic       violation;
  logic       accept;
  logic       reg_mismatch;

  // The instruction word and trap flag carry no cross-instruction rule here:
  // a trapped instruction still supplies the next PC through pc_wdata.
  logic unused_ok;
  assign unused_ok = ^{rvfi.rvfi_insn, rvfi.rvfi_trap};

`ifdef RVFI_CHK_REGFILE_EN
  logic [XLEN-1:0] sh_rs1_data;
  logic [XLEN-1:0] sh_rs2_data;
  logic            sh_rs1_known;
  logic            sh_rs2_known;

  rvfi_shadow_regs #(
    .XLEN (XLEN)
  ) u_shadow_regs (
    .clk       (clk),
    .resetn    (resetn),
    .rs1_addr  (rvfi.rvfi_rs1_addr),
    .rs2_addr  (rvfi.rvfi_rs2_addr),
    .rs1_data  (sh_rs1_data),
    .rs2_data  (sh_rs2_data),
    .rs1_known (sh_rs1_known),
    .rs2_known (sh_rs2_known),
    .we        (accept && (rvfi.rvfi_rd_addr != '0)),
    .waddr     (rvfi.rvfi_rd_addr),
    .wdata     (rvfi.rvfi_rd_wdata)
  );

  // Unknown registers are accepted as read; only known ones are compared.
  assign reg_mismatch = (sh_rs1_known && (rvfi.rvfi_rs1_rdata != sh_rs1_data)) ||
                        (sh_rs2_known && (rvfi.rvfi_rs2_rdata != sh_rs2_data));
`else
  assign reg_mismatch = 1'b0;
`endif

  // Violation detection for the retirement presented this cycle.
  always_comb begin
    hits = '0;
    if (rvfi.rvfi_valid) begin
      case (state_q)
        ST_WAIT_FIRST: begin
          hits[ERR_ORDER]    = (rvfi.rvfi_order != '0);
          hits[ERR_RESET_PC] = CHECK_RESET_PC && (rvfi.rvfi_pc_rdata != RESET_PC);
        end
        ST_RUN: begin
          hits[ERR_ORDER] = (rvfi.rvfi_order != exp_order_q);
          // A trap-handler entry is allowed to redirect the PC.
          hits[ERR_PC]    = !rvfi.rvfi_intr && (rvfi.rvfi_pc_rdata != exp_pc_q);
        end
        ST_HALTED: begin
          hits[ERR_HALT_RETIRE] = 1'b1;
        end
        default: begin
        end
      endcase

      if (state_q != ST_ERROR) begin
        hits[ERR_X0_WRITE]     = (rvfi.rvfi_rd_addr == '0) && (rvfi.rvfi_rd_wdata != '0);
        hits[ERR_X0_READ]      = ((rvfi.rvfi_rs1_addr == '0) && (rvfi.rvfi_rs1_rdata != '0)) ||
                                 ((rvfi.rvfi_rs2_addr == '0) && (rvfi.rvfi_rs2_rdata != '0));
        hits[ERR_REG_MISMATCH] = reg_mismatch;
      end
    end
  end

  assign violation = |hits;
  assign accept    = rvfi.rvfi_valid && !violation &&
                     ((state_q == ST_WAIT_FIRST) || (state_q == ST_RUN));

  always_comb begin
    state_d       = state_q;
    exp_order_d   = exp_order_q;
    exp_pc_d      = exp_pc_q;
    err_d         = err_q;
    err_code_d    = err_code_q;
    err_order_d   = err_order_q;
    retired_cnt_d = retired_cnt_q;
    halted_d      = halted_q;

    if (violation) begin
      state_d = ST_ERROR;
      err_d   = 1'b1;
      if (!err_q) begin
        err_code_d  = pick_err(hits);
        err_order_d = rvfi.rvfi_order;
      end
    end else if (accept) begin
      exp_order_d = rvfi.rvfi_order + 64'd1;
      exp_pc_d    = rvfi.rvfi_pc_wdata;
      if (retired_cnt_q != '1) begin
        retired_cnt_d = retired_cnt_q + 32'd1;
      end
      if (rvfi.rvfi_halt) begin
        state_d  = ST_HALTED;
        halted_d = 1'b1;
      end else begin
        state_d  = ST_RUN;
      end
    end else if (rvfi.rvfi_valid && (state_q == ST_ERROR)) begin
      // After the first violation the counter still tracks stream activity.
      if (retired_cnt_q != '1) begin
        retired_cnt_d = retired_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_WAIT_FIRST;
      exp_order_q   <= '0;
      exp_pc_q      <= RESET_PC;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
      err_order_q   <= '0;
      retired_cnt_q <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      exp_order_q   <= exp_order_d;
      exp_pc_q      <= exp_pc_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      err_order_q   <= err_order_d;
      retired_cnt_q <= retired_cnt_d;
      halted_q      <= halted_d;
    end
  end

  assign err         = err_q;
  assign err_code    = err_code_q;
  assign err_order   = err_order_q;
  assign retired_cnt = retired_cnt_q;
  assign halted      = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_rvfi_stream_checker.sv
// ============================================================================
//  Module  : tb_rvfi_stream_checker
//  Purpose : Self-checking bench for rvfi_stream_checker: directed vector
//            table, an asynchronous mid-stream reset sequence and random
//            retirement streams compared against a behavioural model.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rvfi_stream_checker;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        resetn;
  logic        err;
  logic [3:0]  err_code;
  logic [63:0] err_order;
  logic [31:0] retired_cnt;
  logic        halted;

  int checks = 0;
  int errors = 0;

  rvfi_stream_checker_if #(.XLEN(32)) rvfi_if ();

  rvfi_stream_checker #(
    .XLEN           (32),
    .RESET_PC       (RST_PC),
    .CHECK_RESET_PC (1'b1)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rvfi        (rvfi_if),
    .err         (err),
    .err_code    (err_code),
    .err_order   (err_order),
    .retired_cnt (retired_cnt),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          valid;
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] pcw;
    logic [4:0]  rd;
    logic [31:0] rdw;
    logic [4:0]  rs1;
    logic [31:0] rs1d;
    logic [4:0]  rs2;
    logic [31:0] rs2d;
    bit          halt;
    bit          intr;
    bit          e_err;
    logic [3:0]  e_code;
    logic [63:0] e_eorder;
    logic [31:0] e_cnt;
    bit          e_halted;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit rst, bit valid, logic [63:0] order,
                              logic [31:0] pc, logic [31:0] pcw,
                              logic [4:0] rd, logic [31:0] rdw,
                              logic [4:0] rs1, logic [31:0] rs1d,
                              bit halt, bit intr,
                              bit ee, logic [3:0] ec, logic [63:0] eo,
                              logic [31:0] cnt, bit eh);
    vec_t v;
    v.rst = rst; v.valid = valid; v.order = order; v.pc = pc; v.pcw = pcw;
    v.rd = rd; v.rdw = rdw; v.rs1 = rs1; v.rs1d = rs1d; v.rs2 = 5'd0; v.rs2d = 32'd0;
    v.halt = halt; v.intr = intr;
    v.e_err = ee; v.e_code = ec; v.e_eorder = eo; v.e_cnt = cnt; v.e_halted = eh;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(string tag, bit e, logic [3:0] c, logic [63:0] eo,
                               logic [31:0] cnt, bit h);
    chk({tag, ".err"},         64'(err),         64'(e));
    chk({tag, ".err_code"},    64'(err_code),    64'(c));
    chk({tag, ".err_order"},   err_order,        eo);
    chk({tag, ".retired_cnt"}, 64'(retired_cnt), 64'(cnt));
    chk({tag, ".halted"},      64'(halted),      64'(h));
  endtask

  task automatic drive(vec_t v);
    rvfi_if.rvfi_valid     = v.valid;
    rvfi_if.rvfi_order     = v.order;
    rvfi_if.rvfi_insn      = $urandom;
    rvfi_if.rvfi_trap      = 1'($urandom_range(0, 1));
    rvfi_if.rvfi_halt      = v.halt;
    rvfi_if.rvfi_intr      = v.intr;
    rvfi_if.rvfi_rs1_addr  = v.rs1;
    rvfi_if.rvfi_rs2_addr  = v.rs2;
    rvfi_if.rvfi_rs1_rdata = v.rs1d;
    rvfi_if.rvfi_rs2_rdata = v.rs2d;
    rvfi_if.rvfi_rd_addr   = v.rd;
    rvfi_if.rvfi_rd_wdata  = v.rdw;
    rvfi_if.rvfi_pc_rdata  = v.pc;
    rvfi_if.rvfi_pc_wdata  = v.pcw;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rvfi_if.rvfi_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // -------------------- behavioural reference model -----------------------
  bit          m_started, m_halted, m_dead, m_err;
  logic [63:0] m_exp_order, m_eorder;
  logic [31:0] m_exp_pc, m_cnt;
  logic [3:0]  m_code;
  logic [31:0] m_shadow [32];
  bit          m_known  [32];

  task automatic model_reset();
    m_started = 0; m_halted = 0; m_dead = 0; m_err = 0;
    m_exp_order = 0; m_eorder = 0; m_exp_pc = RST_PC; m_cnt = 0; m_code = 0;
    for (int i = 0; i < 32; i++) begin
      m_shadow[i] = 0;
      m_known[i]  = 0;
    end
  endtask

  task automatic model_step(vec_t v);
    bit codes [1:7];
    int first;
    if (!v.valid) return;
    if (m_dead) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      return;
    end
    for (int i = 1; i <= 7; i++) codes[i] = 0;
    if (m_halted) codes[6] = 1;
    else begin
      if (v.order != m_exp_order) codes[1] = 1;
      if (!m_started) begin
        if (v.pc != RST_PC) codes[3] = 1;
      end else if (!v.intr && v.pc != m_exp_pc) codes[2] = 1;
    end
    if (v.rd == 0 && v.rdw != 0) codes[4] = 1;
    if ((v.rs1 == 0 && v.rs1d != 0) || (v.rs2 == 0 && v.rs2d != 0)) codes[5] = 1;
`ifdef RVFI_CHK_REGFILE_EN
    if (m_known[v.rs1] && v.rs1d != m_shadow[v.rs1]) codes[7] = 1;
    if (m_known[v.rs2] && v.rs2d != m_shadow[v.rs2]) codes[7] = 1;
`endif
    first = 0;
    for (int i = 1; i <= 7; i++) begin
      if (codes[i] && first == 0) first = i;
    end
    if (first != 0) begin
      m_dead = 1; m_err = 1; m_code = 4'(first); m_eorder = v.order;
      return;
    end
    m_started   = 1;
    m_exp_order = v.order + 1;
    m_exp_pc    = v.pcw;
    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (v.halt) m_halted = 1;
    if (v.rd != 0) begin
      m_shadow[v.rd] = v.rdw;
      m_known[v.rd]  = 1;
    end
  endtask

  function automatic vec_t gen_vec();
    vec_t v;
    v.rst   = 0;
    v.valid = ($urandom_range(0, 9) < 8);
    v.order = m_exp_order;
    if ($urandom_range(0, 29) == 0) v.order = m_exp_order + 64'($urandom_range(1, 3));
    v.intr  = ($urandom_range(0, 11) == 0);
    v.pc    = m_started ? m_exp_pc : RST_PC;
    if (v.intr) v.pc = 32'($urandom_range(0, 1023)) << 2;
    if ($urandom_range(0, 29) == 0) v.pc = v.pc ^ 32'h4;
    v.pcw   = ($urandom_range(0, 3) == 0) ? (32'($urandom_range(0, 1023)) << 2) : v.pc + 4;
    v.rd    = 5'($urandom_range(0, 7));
    v.rdw   = (v.rd == 0) ? (($urandom_range(0, 29) == 0) ? 32'd1 : 32'd0) : $urandom;
    v.rs1   = 5'($urandom_range(0, 7));
    v.rs2   = 5'($urandom_range(0, 7));
    v.rs1d  = (m_known[v.rs1] && $urandom_range(0, 19) != 0) ? m_shadow[v.rs1] : $urandom;
    v.rs2d  = (m_known[v.rs2] && $urandom_range(0, 19) != 0) ? m_shadow[v.rs2] : $urandom;
    if (v.rs1 == 0) v.rs1d = ($urandom_range(0, 29) == 0) ? 32'd3 : 32'd0;
    if (v.rs2 == 0) v.rs2d = ($urandom_range(0, 29) == 0) ? 32'd9 : 32'd0;
    v.halt  = ($urandom_range(0, 39) == 0);
    v.e_err = 0; v.e_code = 0; v.e_eorder = 0; v.e_cnt = 0; v.e_halted = 0;
    return v;
  endfunction

  initial begin
    resetn = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Initial reset and reset-value check.
    do_reset();
    #1;
    check_outputs("reset", 0, 0, 0, 0, 0);

    // ------------------------- directed table ---------------------------
    // Clean run 0,1,2 with PCs 0->4->8, then an idle cycle.
    vt.push_back(mk(1, 1, 0, 0,  4, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 1, 4,  8, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0));
    vt.push_back(mk(0, 1, 2, 8, 12, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 0));
    vt.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 0));
    // Order gap 0,1,3; later PC error must not change the code.
    vt.push_back(mk(1, 1, 0, 0,  4, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 1, 4,  8, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0));
    vt.push_back(mk(0, 1, 3, 8, 12, 0, 0, 0, 0, 0, 0,  1, 1, 3, 2, 0));
    vt.push_back(mk(0, 1, 4, 100, 104, 0, 0, 0, 0, 0, 0, 1, 1, 3, 3, 0));
    // PC discontinuity without intr.
    vt.push_back(mk(1, 1, 0, 0,  4, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 1, 8, 12, 0, 0, 0, 0, 0, 0,  1, 2, 1, 1, 0));
    // Same redirect with intr is legal.
    vt.push_back(mk(1, 1, 0, 0,  4, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 1, 8, 12, 0, 0, 0, 0, 0, 1,  0, 0, 0, 2, 0));
    vt.push_back(mk(0, 1, 2, 12, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
    // Order error and x0 write together: lowest code wins.
    vt.push_back(mk(1, 1, 0, 0,  4, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 2, 4,  8, 0, 5, 0, 0, 0, 0,  1, 1, 2, 1, 0));
    // Halt on order 4, then a further retirement.
    vt.push_back(mk(1, 1, 0, 0,  4, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 1, 4,  8, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0));
    vt.push_back(mk(0, 1, 2, 8, 12, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 0));
    vt.push_back(mk(0, 1, 3, 12, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0));
    vt.push_back(mk(0, 1, 4, 16, 20, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5, 1));
    vt.push_back(mk(0, 1, 5, 20, 24, 0, 0, 0, 0, 0, 0, 1, 6, 5, 5, 1));
    // Wrong first PC.
    vt.push_back(mk(1, 1, 0, 32'h100, 32'h104, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0));
    // x0 read returning nonzero.
    vt.push_back(mk(1, 1, 0, 0,  4, 0, 0, 0, 7, 0, 0,  1, 5, 0, 0, 0));
    // x0 write, then valids keep counting in the error state.
    vt.push_back(mk(1, 1, 0, 0,  4, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 1, 4,  8, 0, 5, 0, 0, 0, 0,  1, 4, 1, 1, 0));
    vt.push_back(mk(0, 1, 9, 0,  0, 0, 0, 0, 0, 0, 0,  1, 4, 1, 2, 0));
    // Halt on the very first retirement.
    vt.push_back(mk(1, 1, 0, 0,  4, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1));
    vt.push_back(mk(0, 1, 1, 4,  8, 0, 0, 0, 0, 0, 0,  1, 6, 1, 1, 1));
    // After halt an x0 write (code 4) outranks HALT_RETIRE (code 6).
    vt.push_back(mk(1, 1, 0, 0,  4, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1));
    vt.push_back(mk(0, 1, 1, 4,  8, 0, 9, 0, 0, 0, 0,  1, 4, 1, 1, 1));
`ifdef RVFI_CHK_REGFILE_EN
    // Write x5, same-register read/write, then a stale read.
    vt.push_back(mk(1, 1, 0, 0,  4, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 1, 4,  8, 5, 32'd1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 2, 0));
    vt.push_back(mk(0, 1, 2, 8, 12, 0, 0, 5, 32'h0, 0, 0, 1, 7, 2, 2, 0));
    // Reset between write and read clears the known bits.
    vt.push_back(mk(1, 1, 0, 0,  4, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 1, 0, 0,  4, 0, 0, 5, 32'h0, 0, 0, 0, 0, 0, 1, 0));
`else
    // Without the shadow file a stale read is not a violation.
    vt.push_back(mk(1, 1, 0, 0,  4, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 1, 4,  8, 0, 0, 5, 32'h0, 0, 0, 0, 0, 0, 2, 0));
`endif

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      @(negedge clk);
      drive(vt[i]);
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vt[i].e_err, vt[i].e_code,
                    vt[i].e_eorder, vt[i].e_cnt, vt[i].e_halted);
    end

    // -------------- asynchronous reset in the middle of a run --------------
    do_reset();
    @(negedge clk); drive(mk(0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); drive(mk(0, 1, 2, 4, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    check_outputs("pre_async", 1, 1, 2, 1, 0);
    #1 resetn = 1'b0;
    #1;
    check_outputs("async_rst", 0, 0, 0, 0, 0);
    rvfi_if.rvfi_valid = 1'b0;
    @(negedge clk); resetn = 1'b1;
    @(negedge clk); drive(mk(0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    check_outputs("post_async", 0, 0, 0, 1, 0);

    // --------------------- random streams vs. model -----------------------
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      model_reset();
      for (int c = 0; c < 60; c++) begin
        vec_t v;
        v = gen_vec();
        @(negedge clk);
        drive(v);
        model_step(v);
        @(posedge clk);
        #1;
        check_outputs($sformatf("rnd%0d_%0d", ep, c), m_err, m_code, m_eorder, m_cnt, m_halted);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
